alu_ex_stage: RTL and testbench

- Execute stage of the MIPS pipeline that sits directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU operation code plus the two operands, performs the operation, and registers the result into a single-entry EX/MEM buffer.
- Uses a valid/ready handshake on both sides, a synchronous flush for branch and exception squashing, and signed-overflow exception detection with a saturating exception counter.

---
 rtl/alu_ex_stage.sv | 180 ++++++++++++++++++
 tb/tb_alu_ex_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ex_stage.sv
// -----------------------------------------------------------------------------
// alu_ex_stage
//
// Execute stage of the MIPS pipeline. It takes the 4-bit ALU operation code
// from the ALU control decoder and the two operands, computes the result, and
// registers the result into a single-entry EX/MEM buffer. Valid/ready
// handshakes are used on both sides. A synchronous flush squashes both the
// held entry and the incoming operation. Signed overflow on add/sub raises
// an exception, and a saturating counter tallies those exceptions.
//
// Ports:
//   clk            in   pipeline clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   in_valid       in   upstream holds a valid operation
//   in_ready       out  stage can accept an operation this cycle
//   alu_ctrl[3:0]  in   operation code (0 add .. 11 sra, 12-15 reserved)
//   src_a          in   operand A (rs)
//   src_b          in   operand B (rt or extended immediate)
//   shamt[4:0]     in   shift amount for sll/srl/sra
//   rd_in          in   destination register index
//   reg_write_in   in   operation writes the register file
//   flush          in   squash held and incoming operation
//   out_valid      out  registered result is valid
//   out_ready      in   downstream (MEM) accepts result
//   result         out  registered ALU result
//   zero           out  registered (result == 0)
//   overflow       out  registered signed-overflow exception flag
//   rd_out         out  registered destination index
//   reg_write_out  out  registered write enable, forced 0 on overflow
//   exc_count      out  saturating count of overflow exceptions issued
// -----------------------------------------------------------------------------
module alu_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [4:0]        shamt,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              reg_write_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic [REG_W-1:0]  rd_out,
    output logic              reg_write_out,
    output logic [CNT_W-1:0]  exc_count
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDU = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9;
    localparam logic [3:0] OP_SUBU = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c)
            return c;
        else
            return c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // -------------------------------------------------------------------------
    // Combinational execute
    // -------------------------------------------------------------------------
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic        [DATA_W-1:0] sum;
    logic        [DATA_W-1:0] diff;
    logic                     add_ovf;
    logic                     sub_ovf;
    logic        [DATA_W-1:0] res_d;
    logic                     ovf_d;

    assign a_s  = src_a;
    assign b_s  = src_b;
    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    // Operand signs agree but the sum's sign differs -> add overflowed.
    assign add_ovf = (src_a[DATA_W-1] == src_b[DATA_W-1]) &&
                     (sum[DATA_W-1]   != src_a[DATA_W-1]);
    // Operand signs differ and the difference takes B's sign -> sub overflowed.
    assign sub_ovf = (src_a[DATA_W-1] != src_b[DATA_W-1]) &&
                     (diff[DATA_W-1]  != src_a[DATA_W-1]);

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unique case (alu_ctrl)
            OP_ADD:  begin res_d = sum;  ovf_d = add_ovf; end
            OP_ADDU: res_d = sum;
            OP_AND:  res_d = src_a & src_b;
            OP_NOR:  res_d = ~(src_a | src_b);
            OP_OR:   res_d = src_a | src_b;
            OP_SLT:  res_d = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: res_d = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
            OP_SLL:  res_d = src_b << shamt;
            OP_SRL:  res_d = src_b >> shamt;
            OP_SUB:  begin res_d = diff; ovf_d = sub_ovf; end
            OP_SUBU: res_d = diff;
            OP_SRA:  res_d = b_s >>> shamt;
            default: begin res_d = '0; ovf_d = 1'b0; end
        endcase
    end

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // -------------------------------------------------------------------------
    // EX/MEM register
    // -------------------------------------------------------------------------
    logic              valid_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              ovf_q;
    logic [REG_W-1:0]  rd_q;
    logic              rw_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (flush)
                valid_q <= 1'b0;
            else if (accept)
                valid_q <= 1'b1;
            else if (out_ready)
                valid_q <= 1'b0;

            if (accept) begin
                result_q <= res_d;
                zero_q   <= (res_d == '0);
                ovf_q    <= ovf_d;
                rd_q     <= rd_in;
                // An excepting instruction must not commit to the register file.
                rw_q     <= reg_write_in && !ovf_d;
                if (ovf_d)
                    cnt_q <= sat_inc(cnt_q);
            end
        end
    end

    assign out_valid     = valid_q;
    assign result        = result_q;
    assign zero          = zero_q;
    assign overflow      = ovf_q;
    assign rd_out        = rd_q;
    assign reg_write_out = rw_q;
    assign exc_count     = cnt_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
module tb_alu_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic [7:0]  exc_count;

    int passed = 0;
    int total  = 0;

    alu_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_ctrl      (alu_ctrl),
        .src_a         (src_a),
        .src_b         (src_b),
        .shamt         (shamt),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .overflow      (overflow),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .exc_count     (exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [4:0] rd, input logic rw);
        alu_ctrl     = op;
        src_a        = a;
        src_b        = b;
        shamt        = sh;
        rd_in        = rd;
        reg_write_in = rw;
    endtask

    // Present one operation for one cycle; on return the result has been captured.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [4:0] rd, input logic rw);
        set_op(op, a, b, sh, rd, rw);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        set_op(4'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_out", rd_out, 0);
        chk("rst_reg_write", reg_write_out, 0);
        chk("rst_exc_count", exc_count, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // add overflow
        issue(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd3, 1'b1);
        chk("add_valid", out_valid, 1);
        chk("add_result", result, 32'h8000_0000);
        chk("add_ovf", overflow, 1);
        chk("add_rw", reg_write_out, 0);
        chk("add_exc", exc_count, 1);
        chk("add_rd", rd_out, 3);

        // addu same operands: no overflow
        issue(4'd1, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd4, 1'b1);
        chk("addu_result", result, 32'h8000_0000);
        chk("addu_ovf", overflow, 0);
        chk("addu_rw", reg_write_out, 1);
        chk("addu_exc", exc_count, 1);

        // sub equal -> zero
        issue(4'd9, 32'd5, 32'd5, 5'd0, 5'd5, 1'b1);
        chk("sub_result", result, 0);
        chk("sub_zero", zero, 1);
        chk("sub_ovf", overflow, 0);

        // sub overflow: 0x80000000 - 1
        issue(4'd9, 32'h8000_0000, 32'd1, 5'd0, 5'd6, 1'b1);
        chk("subovf_result", result, 32'h7FFF_FFFF);
        chk("subovf_ovf", overflow, 1);
        chk("subovf_exc", exc_count, 2);
        chk("subovf_zero", zero, 0);

        issue(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd1, 1'b1);
        chk("slt_result", result, 1);
        issue(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd1, 1'b1);
        chk("sltu_result", result, 0);
        chk("sltu_zero", zero, 1);
        issue(4'd11, 32'd0, 32'h8000_0000, 5'd4, 5'd1, 1'b1);
        chk("sra_result", result, 32'hF800_0000);
        issue(4'd7, 32'd0, 32'd1, 5'd31, 5'd1, 1'b1);
        chk("sll_result", result, 32'h8000_0000);
        issue(4'd8, 32'd0, 32'h8000_0000, 5'd4, 5'd1, 1'b1);
        chk("srl_result", result, 32'h0800_0000);
        issue(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 5'd1, 1'b1);
        chk("and_result", result, 32'h0000_F000);
        issue(4'd4, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 5'd1, 1'b1);
        chk("or_result", result, 32'h0000_FFF0);
        issue(4'd3, 32'd0, 32'd0, 5'd0, 5'd1, 1'b1);
        chk("nor_result", result, 32'hFFFF_FFFF);
        issue(4'd10, 32'd0, 32'd1, 5'd0, 5'd1, 1'b1);
        chk("subu_result", result, 32'hFFFF_FFFF);
        chk("subu_ovf", overflow, 0);
        issue(4'd12, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd1, 1'b1);
        chk("rsvd_result", result, 0);
        chk("rsvd_ovf", overflow, 0);
        chk("rsvd_exc", exc_count, 2);

        // Drain with nothing new
        @(negedge clk);
        chk("drain_valid", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        issue(4'd1, 32'd10, 32'd20, 5'd0, 5'd7, 1'b1);
        chk("bp_result0", result, 30);
        chk("bp_in_ready0", in_ready, 0);
        set_op(4'd1, 32'd1, 32'd2, 5'd0, 5'd8, 1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_result", result, 30);
            chk("bp_hold_rd", rd_out, 7);
            chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_result", result, 3);
        chk("bp_next_rd", rd_out, 8);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // Flush of an overflowing add into an empty stage
        set_op(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd9, 1'b1);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_exc", exc_count, 2);

        // Flush of a held entry under backpressure
        out_ready = 1'b0;
        issue(4'd1, 32'd1, 32'd1, 5'd0, 5'd2, 1'b1);
        chk("flush_hold_pre", out_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        chk("flush_hold_valid", out_valid, 0);

        // Saturation: 300 back-to-back overflowing adds, count starts at 2
        set_op(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd9, 1'b1);
        in_valid = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 250) chk("sat_mid", exc_count, 252);
        end
        in_valid = 1'b0;
        chk("sat_end", exc_count, 255);
        chk("sat_valid", out_valid, 1);
        chk("sat_rw", reg_write_out, 0);

        // Reset mid-operation
        out_ready = 1'b0;
        issue(4'd1, 32'd3, 32'd4, 5'd0, 5'd5, 1'b1);
        chk("mid_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_result", result, 0);
        chk("mid_rd", rd_out, 0);
        chk("mid_rw", reg_write_out, 0);
        chk("mid_exc", exc_count, 0);
        chk("mid_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_valid_after", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
